// File: rtl/rv32i_pkg.sv
// Shared RV32 definitions: M-extension op encoding, multiply/divide
// sequencer states and op classification helpers.
package rv32i_pkg;

    localparam int DPW = 32;
    localparam int MD_CNTW = $clog2(DPW);

    typedef enum logic [2:0] {
        MD_MUL,
        MD_MULH,
        MD_MULHSU,
        MD_MULHU,
        MD_DIV,
        MD_DIVU,
        MD_REM,
        MD_REMU
    } md_op_t;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_e;

    function automatic logic md_is_signed_a(input md_op_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_is_signed_b(input md_op_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_is_div(input md_op_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Radix-2 RV32M multiply/divide sequencer beside the execute-stage ALU;
// stalls the front end while iterating and pulses done_o with the result.
module muldiv_sequencer
    import rv32i_pkg::*;
#(
    parameter int WIDTH = DPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  md_op_t           op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic [4:0]       rd_i,
    input  logic             kill_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e        state, stateN;
    md_op_t           opReg;
    logic [WIDTH-1:0] aReg, bReg;
    logic [4:0]       rdReg;
    logic [WIDTH-1:0] hi, lo, dvs;
    logic [CW-1:0]    cnt;
    logic             negQ, negR, zeroQ, ovfQ;

    logic             isDiv, sA, sB, divZero, divOvf;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH:0]   mulSum, divRem;
    logic [WIDTH-1:0] divDiff;
    logic             divGe;
    logic [2*WIDTH-1:0] prod, prodS;
    logic [WIDTH-1:0] quot, rem, resSel;

    always_comb begin
        isDiv   = md_is_div(opReg);
        sA      = md_is_signed_a(opReg) & aReg[WIDTH-1];
        sB      = md_is_signed_b(opReg) & bReg[WIDTH-1];
        magA    = sA ? -aReg : aReg;
        magB    = sB ? -bReg : bReg;
        divZero = isDiv && (bReg == '0);
        divOvf  = isDiv && md_is_signed_a(opReg)
                  && (aReg == MINV) && (bReg == '1);
    end

    // hi:lo is the product during MUL and remainder:quotient during DIV
    always_comb begin
        mulSum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        divRem  = {hi, lo[WIDTH-1]};
        divGe   = divRem >= {1'b0, dvs};
        divDiff = divRem[WIDTH-1:0] - dvs;
    end

    always_comb begin
        prod  = {hi, lo};
        prodS = negQ ? -prod : prod;
        quot  = negQ ? -lo : lo;
        rem   = negR ? -hi : hi;
        if (zeroQ) begin
            quot = '1;
            rem  = aReg;
        end else if (ovfQ) begin
            quot = aReg;
            rem  = '0;
        end
        resSel = '0;
        unique case (1'b1)
            opReg == MD_MUL:  resSel = prodS[WIDTH-1:0];
            opReg inside {MD_MULH, MD_MULHSU, MD_MULHU}:
                              resSel = prodS[2*WIDTH-1:WIDTH];
            opReg inside {MD_DIV, MD_DIVU}:
                              resSel = quot;
            opReg inside {MD_REM, MD_REMU}:
                              resSel = rem;
            default:          resSel = '0;
        endcase
    end

    always_comb begin
        stateN = state;
        unique case (state)
            MD_IDLE: if (start_i) stateN = MD_PREP;
            MD_PREP: stateN = (divZero || divOvf) ? MD_FIX : MD_CALC;
            MD_CALC: if (cnt == LAST) stateN = MD_FIX;
            MD_FIX:  stateN = MD_DONE;
            MD_DONE: stateN = MD_IDLE;
            default: stateN = MD_IDLE;
        endcase
        if (kill_i) stateN = MD_IDLE;
    end

    assign stall_o = ((state == MD_IDLE) & start_i)
                   | (state == MD_PREP)
                   | (state == MD_CALC)
                   | (state == MD_FIX);
    assign done_o  = (state == MD_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= MD_IDLE;
            opReg    <= MD_MUL;
            aReg     <= '0;
            bReg     <= '0;
            rdReg    <= '0;
            hi       <= '0;
            lo       <= '0;
            dvs      <= '0;
            cnt      <= '0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
            zeroQ    <= 1'b0;
            ovfQ     <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            state <= stateN;
            unique case (state)
                MD_IDLE: if (start_i && !kill_i) begin
                    opReg <= op_i;
                    aReg  <= opa_i;
                    bReg  <= opb_i;
                    rdReg <= rd_i;
                end
                MD_PREP: begin
                    hi    <= '0;
                    lo    <= magA;
                    dvs   <= magB;
                    cnt   <= '0;
                    negQ  <= sA ^ sB;
                    negR  <= sA;
                    zeroQ <= divZero;
                    ovfQ  <= divOvf;
                end
                MD_CALC: begin
                    if (isDiv) begin
                        hi <= divGe ? divDiff : divRem[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], divGe};
                    end else begin
                        hi <= mulSum[WIDTH:1];
                        lo <= {mulSum[0], lo[WIDTH-1:1]};
                    end
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                MD_FIX: if (!kill_i) begin
                    result_o <= resSel;
                    rd_o     <= rdReg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, stall, kill,
// reset and start handling around DONE.
module tb_muldiv_sequencer;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    md_op_t      op;
    logic [31:0] opa, opb;
    logic [4:0]  rd;
    logic        stall, done;
    logic [31:0] result;
    logic [4:0]  rdOut;

    int nAssert = 0;
    int nFail = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .op_i     (op),
        .opa_i    (opa),
        .opb_i    (opb),
        .rd_i     (rd),
        .kill_i   (kill),
        .stall_o  (stall),
        .done_o   (done),
        .result_o (result),
        .rd_o     (rdOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic runOp(input string tag, input md_op_t o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] expRes,
                         input int expLat);
        int lat;
        int stl;
        @(negedge clk);
        op = o; opa = a; opb = b; rd = r; start = 1'b1;
        #1;
        stl = stall ? 1 : 0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (stall) stl++;
        end while (!done && lat < 100);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(expLat));
        chk({tag, " result"}, result, expRes);
        chk({tag, " rd"}, 32'(rdOut), 32'(r));
        chk({tag, " stallcyc"}, 32'(stl), 32'(expLat));
        @(posedge clk);
        #1;
        chk({tag, " pulse"}, 32'(done), 32'd0);
        chk({tag, " hold"}, result, expRes);
    endtask

    initial begin
        int cnt;
        int first;
        int second;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0;
        op = MD_MUL; opa = '0; opb = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst rd", 32'(rdOut), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFD, 35);
        runOp("rem", MD_REM, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFF, 35);
        runOp("divu0", MD_DIVU, 32'h1234, 32'd0, 5'd5, 32'hFFFFFFFF, 3);
        runOp("remu0", MD_REMU, 32'h1234, 32'd0, 5'd6, 32'h00001234, 3);
        runOp("divovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd7,
              32'h80000000, 3);
        runOp("removf", MD_REM, 32'h80000000, 32'hFFFFFFFF, 5'd8,
              32'h00000000, 3);
        runOp("mul", MD_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,
              32'h00000001, 35);
        runOp("mulhu", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10,
              32'hFFFFFFFE, 35);
        runOp("mulh", MD_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11,
              32'h00000000, 35);
        runOp("mulhmin", MD_MULH, 32'h80000000, 32'h80000000, 5'd12,
              32'h40000000, 35);
        runOp("mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13,
              32'hFFFFFFFF, 35);
        runOp("mul3x5", MD_MUL, 32'd3, 32'hFFFFFFFB, 5'd14,
              32'hFFFFFFF1, 35);

        // kill at CALC cycle 10
        @(negedge clk);
        op = MD_MULHU; opa = 32'h12345678; opb = 32'h9ABCDEF0;
        rd = 5'd20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill stall", 32'(stall), 32'd0);
        chk("kill done", 32'(done), 32'd0);
        chk("kill result", result, 32'hFFFFFFF1);
        chk("kill rd", 32'(rdOut), 32'd14);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        chk("kill nodone", 32'(cnt), 32'd0);
        runOp("divu", MD_DIVU, 32'd100, 32'd7, 5'd21, 32'h0000000E, 35);

        // reset mid-CALC
        @(negedge clk);
        op = MD_DIV; opa = 32'd1000; opb = 32'd3; rd = 5'd22; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst done", 32'(done), 32'd0);
        chk("mrst result", result, 32'd0);
        chk("mrst rd", 32'(rdOut), 32'd0);
        chk("mrst stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        chk("mrst nodone", 32'(cnt), 32'd0);

        // start pulsed in DONE is not taken
        @(negedge clk);
        op = MD_DIVU; opa = 32'h1234; opb = 32'd0; rd = 5'd23; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("dstart done", 32'(done), 32'd1);
        start = 1'b1;
        #1;
        chk("dstart stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        chk("dstart idle", 32'(stall), 32'd0);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        chk("dstart nodone", 32'(cnt), 32'd0);

        // start held across DONE: two separate ops
        @(negedge clk);
        op = MD_DIVU; opa = 32'd100; opb = 32'd7; rd = 5'd24; start = 1'b1;
        cnt = 0; first = 0; second = 0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (i == 37) start = 1'b0;
            if (done) begin
                cnt++;
                if (cnt == 1) first = i;
                else second = i;
            end
        end
        chk("b2b count", 32'(cnt), 32'd2);
        chk("b2b first", 32'(first), 32'd35);
        chk("b2b second", 32'(second), 32'd71);
        chk("b2b result", result, 32'h0000000E);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule
